// File: rtl/fir_axil_pkg.sv
// Shared definitions for the FIR AXI4-Lite register file.
// Contents: AXI response codes, write/read FSM state enums, and the
// constant clog2 helper used to derive word-index widths.
package fir_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}                     rd_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fir_axil_regfile_if.sv
// AXI4-Lite bus bundle between the interconnect master port and the
// FIR register file. The slave modport is used by fir_axil_regfile;
// the master modport is the interconnect / bench view.
interface fir_axil_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) ();
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/fir_axil_wr_ctrl.sv
// Write-channel controller: accepts AW and W independently, latches
// address/data/strobe at their handshakes, and issues a single-cycle
// write strobe (wr_en_o/wr_idx_o/wr_data_o/wr_strb_o) on the edge that
// enters W_RESP. Holds BVALID/BRESP until BREADY; one write outstanding.
// Ports: clk_i/rst_ni, AW (awaddr_i/awvalid_i/awready_o),
// W (wdata_i/wstrb_i/wvalid_i/wready_o), B (bresp_o/bvalid_o/bready_i),
// register-array write strobe outputs.
module fir_axil_wr_ctrl
  import fir_axil_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 6,
  parameter  int N_REGS = 8,
  localparam int STRB_W = DATA_W / 8,
  localparam int LSB    = clog2(STRB_W),
  localparam int IDX_W  = ADDR_W - LSB
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  output logic              wr_en_o,
  output logic [IDX_W-1:0]  wr_idx_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [STRB_W-1:0] wr_strb_o
);
  wr_state_t         state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB_W-1:0] strb_q;
  logic [1:0]        bresp_q;
  logic              aw_hs, w_hs;
  logic              unused_lsb;

  assign unused_lsb = ^awaddr_i[LSB-1:0];

  // Readies are gated by the reset input so they read 0 while ARESETN is low.
  assign awready_o = rst_ni && (state_q == W_IDLE || state_q == W_HAVE_D);
  assign wready_o  = rst_ni && (state_q == W_IDLE || state_q == W_HAVE_A);
  assign aw_hs     = awvalid_i && awready_o;
  assign w_hs      = wvalid_i && wready_o;
  assign bvalid_o  = (state_q == W_RESP);
  assign bresp_o   = bresp_q;

  // The half arriving this cycle comes straight off the bus, the other from its latch.
  assign wr_idx_o  = aw_hs ? awaddr_i[ADDR_W-1:LSB] : idx_q;
  assign wr_data_o = w_hs ? wdata_i : data_q;
  assign wr_strb_o = w_hs ? wstrb_i : strb_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) state_d = W_RESP;
        else if (aw_hs)    state_d = W_HAVE_A;
        else if (w_hs)     state_d = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)     state_d = W_RESP;
      W_HAVE_D: if (aw_hs)    state_d = W_RESP;
      W_RESP:   if (bready_i) state_d = W_IDLE;
      default:                state_d = W_IDLE;
    endcase
    wr_en_o = (state_q != W_RESP) && (state_d == W_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= W_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (aw_hs) idx_q <= awaddr_i[ADDR_W-1:LSB];
      if (w_hs) begin
        data_q <= wdata_i;
        strb_q <= wstrb_i;
      end
      if (wr_en_o) bresp_q <= (wr_idx_o < IDX_W'(N_REGS)) ? RESP_OKAY : RESP_SLVERR;
    end
  end
endmodule

// File: rtl/fir_axil_regfile.sv
// AXI4-Lite slave register file for the FIR datapath.
// reg0 = CTRL, reg1..N_REGS-1 = coefficients, index N_REGS = read-only
// STATUS (live status_i), higher indices decode to SLVERR.
// Ports: ACLK, ARESETN (async, active low), axi (slave modport),
// status_i (FIR status), coef_o (word k at [k*DATA_W +: DATA_W]),
// commit_o (shadow commit pulse).
// Build option FIR_AXIL_SHADOW_EN: coefficient words reach coef_o only
// through a shadow copy taken when CTRL bit0 is written as 1; that bit
// self-clears. Without it coef_o mirrors the live registers and
// commit_o is tied low.
module fir_axil_regfile
  import fir_axil_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int N_REGS = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  fir_axil_regfile_if.slave        axi,
  input  logic [DATA_W-1:0]        status_i,
  output logic [N_REGS*DATA_W-1:0] coef_o,
  output logic                     commit_o
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;

  rd_state_t         rd_state_q, rd_state_d;
  logic [DATA_W-1:0] rdata_q, rd_word;
  logic [1:0]        rresp_q, rd_resp;
  logic              arready, ar_hs;
  logic [IDX_W-1:0]  ar_idx;
  logic              unused_top;

  assign unused_top = ^{axi.S_AXI_AWPROT, axi.S_AXI_ARPROT, axi.S_AXI_ARADDR[LSB-1:0]};

  fir_axil_wr_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_REGS(N_REGS)) u_wr_ctrl (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .awaddr_i  (axi.S_AXI_AWADDR),
    .awvalid_i (axi.S_AXI_AWVALID),
    .awready_o (axi.S_AXI_AWREADY),
    .wdata_i   (axi.S_AXI_WDATA),
    .wstrb_i   (axi.S_AXI_WSTRB),
    .wvalid_i  (axi.S_AXI_WVALID),
    .wready_o  (axi.S_AXI_WREADY),
    .bresp_o   (axi.S_AXI_BRESP),
    .bvalid_o  (axi.S_AXI_BVALID),
    .bready_i  (axi.S_AXI_BREADY),
    .wr_en_o   (wr_en),
    .wr_idx_o  (wr_idx),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < N_REGS; k++) regs_q[k] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < N_REGS; k++) begin
        if (wr_idx == IDX_W'(k)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs_q[k][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
`ifdef FIR_AXIL_SHADOW_EN
      // Commit request bit is never stored; it only triggers the shadow copy.
      if (wr_idx == '0 && wr_strb[0]) regs_q[0][0] <= 1'b0;
`endif
    end
  end

`ifdef FIR_AXIL_SHADOW_EN
  logic [DATA_W-1:0] shadow_q [N_REGS];
  logic              commit_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      commit_q <= 1'b0;
      for (int k = 0; k < N_REGS; k++) shadow_q[k] <= '0;
    end else begin
      commit_q <= wr_en && (wr_idx == '0) && wr_strb[0] && wr_data[0];
      // Copy one edge after the CTRL write so the copy sees every completed write.
      if (commit_q) begin
        for (int k = 1; k < N_REGS; k++) shadow_q[k] <= regs_q[k];
      end
    end
  end

  assign commit_o = commit_q;
  for (genvar k = 0; k < N_REGS; k++) begin : g_coef
    if (k == 0) begin : g_ctrl
      assign coef_o[k*DATA_W +: DATA_W] = regs_q[k];
    end else begin : g_shadow
      assign coef_o[k*DATA_W +: DATA_W] = shadow_q[k];
    end
  end
`else
  assign commit_o = 1'b0;
  for (genvar k = 0; k < N_REGS; k++) begin : g_coef
    assign coef_o[k*DATA_W +: DATA_W] = regs_q[k];
  end
`endif

  assign arready           = ARESETN && (rd_state_q == R_IDLE);
  assign ar_hs             = axi.S_AXI_ARVALID && arready;
  assign ar_idx            = axi.S_AXI_ARADDR[ADDR_W-1:LSB];
  assign axi.S_AXI_ARREADY = arready;
  assign axi.S_AXI_RVALID  = (rd_state_q == R_DATA);
  assign axi.S_AXI_RDATA   = rdata_q;
  assign axi.S_AXI_RRESP   = rresp_q;

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (ar_hs)              rd_state_d = R_DATA;
      R_DATA:  if (axi.S_AXI_RREADY)   rd_state_d = R_IDLE;
      default:                         rd_state_d = R_IDLE;
    endcase
  end

  // Read decode samples regs_q before any same-edge write lands.
  always_comb begin
    rd_word = '0;
    rd_resp = RESP_SLVERR;
    if (ar_idx == IDX_W'(N_REGS)) begin
      rd_word = status_i;
      rd_resp = RESP_OKAY;
    end
    for (int k = 0; k < N_REGS; k++) begin
      if (ar_idx == IDX_W'(k)) begin
        rd_word = regs_q[k];
        rd_resp = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      if (ar_hs) begin
        rdata_q <= rd_word;
        rresp_q <= rd_resp;
      end
    end
  end
endmodule

// File: tb/tb_fir_axil_regfile.sv
module tb_fir_axil_regfile;
  import fir_axil_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int N_REGS = 8;
`ifdef FIR_AXIL_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic                     aclk = 1'b0;
  logic                     aresetn;
  logic [DATA_W-1:0]        status;
  logic [N_REGS*DATA_W-1:0] coef;
  logic                     commit;

  fir_axil_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fir_axil_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_REGS(N_REGS)) dut (
    .ACLK     (aclk),
    .ARESETN  (aresetn),
    .axi      (bus),
    .status_i (status),
    .coef_o   (coef),
    .commit_o (commit)
  );

  always #5 aclk = ~aclk;

  int n_pass = 0, n_total = 0;
  int commit_cnt = 0, bvalid_cnt = 0, m_commits = 0;

  always @(negedge aclk) begin
    if (commit) commit_cnt++;
    if (bus.S_AXI_BVALID) bvalid_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: word array plus shadow copy, plain arithmetic on byte lanes.
  logic [31:0] mdl [N_REGS];
  logic [31:0] msh [N_REGS];

  function automatic logic [1:0] model_write(input logic [5:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    int idx;
    idx = int'(a) / 4;
    if (idx >= N_REGS) return RESP_SLVERR;
    for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
    if (SH && idx == 0 && s[0] && d[0]) begin
      mdl[0][0] = 1'b0;
      for (int k = 1; k < N_REGS; k++) msh[k] = mdl[k];
      m_commits++;
    end
    return RESP_OKAY;
  endfunction

  task automatic model_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    int idx;
    idx = int'(a) / 4;
    if (idx < N_REGS)       begin d = mdl[idx]; r = RESP_OKAY;   end
    else if (idx == N_REGS) begin d = status;   r = RESP_OKAY;   end
    else                    begin d = '0;       r = RESP_SLVERR; end
  endtask

  function automatic logic [31:0] model_coef(input int k);
    return (SH && k > 0) ? msh[k] : mdl[k];
  endfunction

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output bit ok);
    bit aw_done, w_done, aw_hit, w_hit;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; resp = '0;
    @(negedge aclk);
    bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
    while (!(aw_done && w_done) && cyc <= 60) begin
      if (!aw_done && cyc >= aw_dly) bus.S_AXI_AWVALID = 1'b1;
      if (!w_done && cyc >= w_dly)   bus.S_AXI_WVALID  = 1'b1;
      aw_hit = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hit  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(negedge aclk); cyc++;
      if (aw_hit) begin aw_done = 1; bus.S_AXI_AWVALID = 1'b0; end
      if (w_hit)  begin w_done = 1;  bus.S_AXI_WVALID  = 1'b0; end
    end
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    while (aw_done && w_done && !bus.S_AXI_BVALID && cyc <= 60) begin
      @(negedge aclk); cyc++;
    end
    ok = aw_done && w_done && bus.S_AXI_BVALID;
    if (ok) begin
      resp = bus.S_AXI_BRESP;
      @(negedge aclk);
    end
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r,
                          output bit ok);
    bit hit;
    int cyc;
    hit = 0; cyc = 0;
    @(negedge aclk);
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1;
    while (!hit && cyc <= 60) begin
      hit = bus.S_AXI_ARREADY;
      @(negedge aclk); cyc++;
    end
    bus.S_AXI_ARVALID = 1'b0;
    while (hit && !bus.S_AXI_RVALID && cyc <= 60) begin
      @(negedge aclk); cyc++;
    end
    ok = hit && bus.S_AXI_RVALID;
    d = bus.S_AXI_RDATA; r = bus.S_AXI_RRESP;
    if (ok) @(negedge aclk);
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [31:0] rd, ed;
    logic [1:0]  rr, br, er;
    logic [5:0]  a;
    logic [31:0] d, old;
    logic [3:0]  s;
    bit          ok;
    int          c0;

    tbl[0] = '{6'h00, 32'h1,        4'hF, RESP_OKAY,   {31'd0, ~SH},  RESP_OKAY};
    tbl[1] = '{6'h04, 32'h2,        4'hF, RESP_OKAY,   32'h2,         RESP_OKAY};
    tbl[2] = '{6'h08, 32'h3,        4'hF, RESP_OKAY,   32'h3,         RESP_OKAY};
    tbl[3] = '{6'h0C, 32'h4,        4'hF, RESP_OKAY,   32'h4,         RESP_OKAY};
    tbl[4] = '{6'h04, 32'hFFFFFFFF, 4'hF, RESP_OKAY,   32'hFFFFFFFF,  RESP_OKAY};
    tbl[5] = '{6'h04, 32'h12345678, 4'h5, RESP_OKAY,   32'hFF34FF78,  RESP_OKAY};
    tbl[6] = '{6'h3C, 32'hDEADBEEF, 4'hF, RESP_SLVERR, 32'h0,         RESP_SLVERR};
    tbl[7] = '{6'h20, 32'h0000CAFE, 4'hF, RESP_SLVERR, 32'h5A5AA5A5,  RESP_OKAY};
    tbl[8] = '{6'h1E, 32'h00000077, 4'hF, RESP_OKAY,   32'h00000077,  RESP_OKAY};
    tbl[9] = '{6'h24, 32'h11111111, 4'hF, RESP_SLVERR, 32'h0,         RESP_SLVERR};

    for (int k = 0; k < N_REGS; k++) begin mdl[k] = '0; msh[k] = '0; end

    aresetn = 1'b0;
    status  = 32'h5A5AA5A5;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;

    // Reset state
    #12;
    chk("rst_awready", bus.S_AXI_AWREADY, 0);
    chk("rst_wready",  bus.S_AXI_WREADY, 0);
    chk("rst_arready", bus.S_AXI_ARREADY, 0);
    chk("rst_bvalid",  bus.S_AXI_BVALID, 0);
    chk("rst_rvalid",  bus.S_AXI_RVALID, 0);
    chk("rst_resp",    {bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 0);
    chk("rst_rdata",   bus.S_AXI_RDATA, 0);
    chk("rst_coef",    (coef == '0), 1);
    chk("rst_commit",  commit, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_awready", bus.S_AXI_AWREADY, 1);
    chk("post_rst_arready", bus.S_AXI_ARREADY, 1);

    // Directed vector table: write then read back the same address
    for (int i = 0; i < 10; i++) begin
      axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, br, ok);
      chk("tbl_wr_ok", ok, 1);
      chk($sformatf("tbl%0d_bresp", i), br, tbl[i].bresp);
      er = model_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
      axi_read(tbl[i].addr, rd, rr, ok);
      chk("tbl_rd_ok", ok, 1);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rdata);
      chk($sformatf("tbl%0d_rresp", i), rr, tbl[i].rresp);
    end

    // W arrives 3 cycles ahead of AW: exactly one response
    c0 = bvalid_cnt;
    axi_write(6'h10, 32'h00004444, 4'hF, 3, 0, br, ok);
    er = model_write(6'h10, 32'h00004444, 4'hF);
    repeat (3) @(negedge aclk);
    chk("w_first_ok", ok, 1);
    chk("w_first_bresp", br, RESP_OKAY);
    chk("w_first_bvalid_cnt", bvalid_cnt - c0, 1);
    axi_read(6'h10, rd, rr, ok);
    chk("w_first_rdata", rd, 32'h00004444);

    // Back-pressure on B: response held, no new AW accepted
    @(negedge aclk);
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_AWADDR = 6'h08; bus.S_AXI_WDATA = 32'h33; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    @(negedge aclk);
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_AWADDR = 6'h10;
    for (int i = 0; i < 5; i++) begin
      chk("bhold_bvalid", bus.S_AXI_BVALID, 1);
      chk("bhold_bresp", bus.S_AXI_BRESP, RESP_OKAY);
      chk("bhold_awready", bus.S_AXI_AWREADY, 0);
      @(negedge aclk);
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    @(negedge aclk);
    chk("bhold_release", bus.S_AXI_BVALID, 0);
    er = model_write(6'h08, 32'h33, 4'hF);

    // Back-pressure on R
    bus.S_AXI_RREADY = 1'b0;
    bus.S_AXI_ARADDR = 6'h08; bus.S_AXI_ARVALID = 1'b1;
    @(negedge aclk);
    bus.S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rhold_rvalid", bus.S_AXI_RVALID, 1);
      chk("rhold_rdata", bus.S_AXI_RDATA, 32'h33);
      chk("rhold_rresp", bus.S_AXI_RRESP, RESP_OKAY);
      chk("rhold_arready", bus.S_AXI_ARREADY, 0);
      @(negedge aclk);
    end
    bus.S_AXI_RREADY = 1'b1;
    @(negedge aclk);
    chk("rhold_release", bus.S_AXI_RVALID, 0);

    // Same-cycle write and read of one index: read returns the old value
    old = mdl[3];
    bus.S_AXI_AWADDR = 6'h0C; bus.S_AXI_WDATA = 32'hABCD0123; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARADDR = 6'h0C;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    @(negedge aclk);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    chk("rw_same_rdata", bus.S_AXI_RDATA, old);
    chk("rw_same_bvalid", bus.S_AXI_BVALID, 1);
    @(negedge aclk);
    er = model_write(6'h0C, 32'hABCD0123, 4'hF);
    axi_read(6'h0C, rd, rr, ok);
    chk("rw_same_after", rd, 32'hABCD0123);

    // Coefficient visibility and commit behaviour
    axi_write(6'h04, 32'h000000A5, 4'hF, 0, 0, br, ok);
    er = model_write(6'h04, 32'h000000A5, 4'hF);
    c0 = commit_cnt;
`ifdef FIR_AXIL_SHADOW_EN
    chk("shadow_word1_held", coef[63:32], msh[1]);
    chk("shadow_word1_not_live", (coef[63:32] == 32'hA5), 0);
    axi_write(6'h00, 32'h1, 4'hF, 0, 0, br, ok);
    er = model_write(6'h00, 32'h1, 4'hF);
    chk("commit_pulse", commit_cnt - c0, 1);
    chk("commit_word1", coef[63:32], 32'hA5);
    axi_read(6'h00, rd, rr, ok);
    chk("commit_ctrl_reads0", rd[0], 0);
`else
    chk("live_word1", coef[63:32], 32'hA5);
    axi_write(6'h00, 32'h1, 4'hF, 0, 0, br, ok);
    er = model_write(6'h00, 32'h1, 4'hF);
    chk("no_commit", commit_cnt - c0, 0);
    chk("live_ctrl_word0", coef[31:0], 32'h1);
    axi_read(6'h00, rd, rr, ok);
    chk("ctrl_bit0_stored", rd[0], 1);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      a = 6'($urandom_range(0, 63));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), br, ok);
      er = model_write(a, d, s);
      chk("rnd_wr_ok", ok, 1);
      chk("rnd_bresp", br, er);
      for (int k = 0; k < N_REGS; k++) chk($sformatf("rnd_coef%0d", k), coef[k*32 +: 32], model_coef(k));
      a = 6'($urandom_range(0, 63));
      status = $urandom;
      axi_read(a, rd, rr, ok);
      model_read(a, ed, er);
      chk("rnd_rd_ok", ok, 1);
      chk("rnd_rdata", rd, ed);
      chk("rnd_rresp", rr, er);
    end
    chk("commit_total", commit_cnt, m_commits);

    // Reset asserted while holding an accepted address (W_HAVE_A)
    @(negedge aclk);
    bus.S_AXI_AWADDR = 6'h04; bus.S_AXI_AWVALID = 1'b1;
    @(negedge aclk);
    bus.S_AXI_AWVALID = 1'b0;
    chk("have_a_awready", bus.S_AXI_AWREADY, 0);
    chk("have_a_wready", bus.S_AXI_WREADY, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("midrst_awready", bus.S_AXI_AWREADY, 0);
    chk("midrst_wready", bus.S_AXI_WREADY, 0);
    chk("midrst_bvalid", bus.S_AXI_BVALID, 0);
    chk("midrst_rvalid", bus.S_AXI_RVALID, 0);
    chk("midrst_rdata", bus.S_AXI_RDATA, 0);
    chk("midrst_coef", (coef == '0), 1);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int k = 0; k < N_REGS; k++) begin mdl[k] = '0; msh[k] = '0; end
    c0 = bvalid_cnt;
    repeat (5) @(negedge aclk);
    chk("midrst_no_bvalid", bvalid_cnt - c0, 0);
    chk("midrst_idle_awready", bus.S_AXI_AWREADY, 1);
    axi_read(6'h04, rd, rr, ok);
    chk("midrst_reg1_cleared", rd, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
